// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (iterative double dabble).
// One add-3/shift step per clock. Start/busy/done handshake, a held result
// register and overflow detection when the value exceeds 10^DIGITS-1.
// Optional leading-zero blanking output is enabled by defining BCD_LZB_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last conversion
// SHIFT | one add-3/shift step per clock, BIN_W steps in total

module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
`ifdef BCD_LZB_EN
    output logic [DIGITS-1:0]     blank,
`endif
    output logic                  overflow
);

    localparam int SR_W  = 4*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                acc_q, acc_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [SR_W-1:0]     adj;
    logic [SR_W-1:0]     shifted;
    logic                out_bit;

    // Add-3 correction on every BCD digit, then the left shift of one step.
    always_comb begin
        adj = sr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (sr_q[BIN_W+4*k +: 4] >= 4'd5) begin
                adj[BIN_W+4*k +: 4] = sr_q[BIN_W+4*k +: 4] + 4'd3;
            end
        end
        out_bit = adj[SR_W-1];
        shifted = {adj[SR_W-2:0], 1'b0};
    end

    // Next-state and register-update logic of the conversion FSM.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {{(4*DIGITS){1'b0}}, bin_in};
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = shifted;
                acc_d = acc_q | out_bit;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    bcd_d   = shifted[SR_W-1 -: 4*DIGITS];
                    ovf_d   = acc_q | out_bit;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

`ifdef BCD_LZB_EN
    // Reset pattern blanks every digit except the ones digit.
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    logic [DIGITS-1:0] blank_q, blank_d;
    logic              zero_above;

    // Digit k is blanked when it and all more significant digits are zero.
    always_comb begin
        blank_d    = blank_q;
        zero_above = 1'b1;
        if (done_d) begin
            blank_d = '0;
            for (int k = DIGITS-1; k >= 1; k--) begin
                zero_above = zero_above & (bcd_d[4*k +: 4] == 4'd0);
                blank_d[k] = zero_above;
            end
        end
    end

    // Blanking mask is registered on the same edge as the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= BLANK_RST;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: a default instance (14 bit, 4 digits) and a
// wide instance (20 bit, 6 digits), with per-instance result scoreboards.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_a, busy_a, done_a, ovf_a;
    logic [13:0] bin_a;
    logic [15:0] bcd_a;
    logic        start_b, busy_b, done_b, ovf_b;
    logic [19:0] bin_b;
    logic [23:0] bcd_b;
`ifdef BCD_LZB_EN
    logic [3:0]  blank_a;
    logic [5:0]  blank_b;
`endif

    bin_to_bcd_seq dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a),
`ifdef BCD_LZB_EN
        .blank(blank_a),
`endif
        .overflow(ovf_a)
    );

    bin_to_bcd_seq #(.BIN_W(20), .DIGITS(6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
`ifdef BCD_LZB_EN
        .blank(blank_b),
`endif
        .overflow(ovf_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        logic [5:0]  blank;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    logic pd_a = 1'b0;
    logic pd_b = 1'b0;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] model_bcd(input int unsigned v, input int d);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] model_blank(input logic [23:0] b, input int d);
        logic [5:0] r;
        logic z;
        r = '0;
        z = 1'b1;
        for (int k = d-1; k >= 1; k--) begin
            z = z & (b[4*k +: 4] == 4'd0);
            r[k] = z;
        end
        return r;
    endfunction

    // Scoreboard for instance A: pop and compare on each done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done_a) begin
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done_a: got done=1 required none (cycle %0d)", cyc);
                end else begin
                    e = q_a.pop_front();
                    chk("bcd_a", 32'(bcd_a), 32'(e.bcd[15:0]));
                    chk("ovf_a", 32'(ovf_a), 32'(e.ovf));
                    chk("latency_a", cyc, e.due);
`ifdef BCD_LZB_EN
                    chk("blank_a", 32'(blank_a), 32'(e.blank[3:0]));
`endif
                end
                if (pd_a) begin
                    checks++; errors++;
                    $display("FAIL done_width_a: got 2+ cycles required 1");
                end
            end
            pd_a = done_a;
        end else begin
            pd_a = 1'b0;
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done_b) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done_b: got done=1 required none (cycle %0d)", cyc);
                end else begin
                    e = q_b.pop_front();
                    chk("bcd_b", 32'(bcd_b), 32'(e.bcd));
                    chk("ovf_b", 32'(ovf_b), 32'(e.ovf));
                    chk("latency_b", cyc, e.due);
`ifdef BCD_LZB_EN
                    chk("blank_b", 32'(blank_b), 32'(e.blank));
`endif
                end
                if (pd_b) begin
                    checks++; errors++;
                    $display("FAIL done_width_b: got 2+ cycles required 1");
                end
            end
            pd_b = done_b;
        end else begin
            pd_b = 1'b0;
        end
    end

    // Called at a negedge: request a conversion for the next rising edge.
    task automatic go_a(input logic [13:0] v, input logic [15:0] eb, input logic eo,
                        input logic [3:0] ebl);
        exp_t e;
        start_a = 1'b1;
        bin_a   = v;
        if (!busy_a) begin
            e.bcd = {8'h00, eb}; e.ovf = eo; e.blank = {2'b00, ebl}; e.due = cyc + 15;
            q_a.push_back(e);
        end
        @(negedge clk);
        start_a = 1'b0;
        bin_a   = 14'h3abc;
    endtask

    task automatic go_b(input logic [19:0] v, input logic [23:0] eb, input logic eo,
                        input logic [5:0] ebl);
        exp_t e;
        start_b = 1'b1;
        bin_b   = v;
        if (!busy_b) begin
            e.bcd = eb; e.ovf = eo; e.blank = ebl; e.due = cyc + 21;
            q_b.push_back(e);
        end
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic wait_done_a(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (done_a) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL timeout_a: got no done required done within %0d cycles", maxc);
    endtask

    task automatic wait_done_b(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (done_b) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL timeout_b: got no done required done within %0d cycles", maxc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt[12];
        int   n;
        int unsigned r;
        logic [23:0] mb;

        vt[0]  = '{14'd7,     16'h0007, 1'b0, 4'b1110};
        vt[1]  = '{14'd42,    16'h0042, 1'b0, 4'b1100};
        vt[2]  = '{14'd100,   16'h0100, 1'b0, 4'b1000};
        vt[3]  = '{14'd8191,  16'h8191, 1'b0, 4'b0000};
        vt[4]  = '{14'd10000, 16'h0000, 1'b1, 4'b1110};
        vt[5]  = '{14'd10005, 16'h0005, 1'b1, 4'b1110};
        vt[6]  = '{14'd9,     16'h0009, 1'b0, 4'b1110};
        vt[7]  = '{14'd10,    16'h0010, 1'b0, 4'b1100};
        vt[8]  = '{14'd1000,  16'h1000, 1'b0, 4'b0000};
        vt[9]  = '{14'd5555,  16'h5555, 1'b0, 4'b0000};
        vt[10] = '{14'd12345, 16'h2345, 1'b1, 4'b0000};
        vt[11] = '{14'd1,     16'h0001, 1'b0, 4'b1110};

        rst = 1'b1;
        start_a = 1'b0; bin_a = '0;
        start_b = 1'b0; bin_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_done_a", 32'(done_a), 0);
        chk("rst_bcd_a", 32'(bcd_a), 0);
        chk("rst_ovf_a", 32'(ovf_a), 0);
        chk("rst_bcd_b", 32'(bcd_b), 0);
`ifdef BCD_LZB_EN
        chk("rst_blank_a", 32'(blank_a), 32'h0e);
        chk("rst_blank_b", 32'(blank_b), 32'h3e);
`endif
        rst = 1'b0;
        @(negedge clk);

        // 1: 9999, busy for 14 cycles
        go_a(14'd9999, 16'h9999, 1'b0, 4'b0000);
        n = 0;
        while (busy_a && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles_a", n, 14);
        chk("done_after_busy_a", 32'(done_a), 1);

        // 2: 0 then 1234 back-to-back
        @(negedge clk);
        go_a(14'd0, 16'h0000, 1'b0, 4'b1110);
        wait_done_a(40);
        go_a(14'd1234, 16'h1234, 1'b0, 4'b0000);
        chk("b2b_busy_a", 32'(busy_a), 1);
        wait_done_a(40);
        @(negedge clk);

        // 3: overflow then sticky clear
        go_a(14'd16383, 16'h6383, 1'b1, 4'b0000);
        wait_done_a(40);
        @(negedge clk);
        go_a(14'd500, 16'h0500, 1'b0, 4'b1000);
        wait_done_a(40);
        @(negedge clk);

        // 4: start while busy is ignored, result held until done
        go_a(14'd4321, 16'h4321, 1'b0, 4'b0000);
        repeat (4) @(negedge clk);
        chk("hold_bcd_a", 32'(bcd_a), 32'h0500);
        chk("hold_ovf_a", 32'(ovf_a), 0);
        go_a(14'd7777, 16'h7777, 1'b0, 4'b0000);
        wait_done_a(40);
        repeat (20) @(negedge clk);

        // 5: asynchronous reset mid-conversion
        go_a(14'd8888, 16'h8888, 1'b0, 4'b0000);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy_a", 32'(busy_a), 0);
        chk("arst_done_a", 32'(done_a), 0);
        chk("arst_bcd_a", 32'(bcd_a), 0);
        chk("arst_ovf_a", 32'(ovf_a), 0);
        q_a.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        go_a(14'd2024, 16'h2024, 1'b0, 4'b0000);
        wait_done_a(40);
        @(negedge clk);

        // table-driven vectors
        for (int i = 0; i < 12; i++) begin
            go_a(vt[i].bin, vt[i].bcd, vt[i].ovf, vt[i].blank);
            wait_done_a(40);
            @(negedge clk);
        end

        // random values against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            r  = $urandom_range(0, 16383);
            mb = model_bcd(r, 4);
            go_a(14'(r), mb[15:0], (r > 9999), model_blank(mb, 4)[3:0]);
            wait_done_a(40);
            @(negedge clk);
        end

        // 6: wide instance
        go_b(20'd999999, 24'h999999, 1'b0, 6'b000000);
        wait_done_b(60);
        @(negedge clk);
        go_b(20'd42, 24'h000042, 1'b0, 6'b111100);
        wait_done_b(60);
        @(negedge clk);
        go_b(20'd0, 24'h000000, 1'b0, 6'b111110);
        wait_done_b(60);
        @(negedge clk);
        go_b(20'd1048575, 24'h048575, 1'b1, 6'b100000);
        wait_done_b(60);
        repeat (5) @(negedge clk);

        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Parametrised, clocked successor to the combinational binary-to-BCD converter. It runs double dabble iteratively, one add-3/shift step per clock, so area stays flat as BIN_W and DIGITS grow. It sits between counter/arithmetic logic and the 7-segment digit mux. It provides a start/busy/done handshake, a held result register and overflow detection.

Parameters:
BIN_W, 14, width of binary input (must be >= 1)
DIGITS, 4, number of BCD output digits (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion of bin_in; sampled only when busy=0
bin_in  input  BIN_W  binary value, captured on accepted start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd_out/overflow update
bcd_out  output  4*DIGITS  result; digit k at [4k+3:4k], digit 0 = ones
overflow  output  1  high if the last result exceeded 10^DIGITS-1
blank  output  DIGITS  present only with BCD_LZB_EN (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high):
  - State is IDLE.
  - busy=0, done=0, overflow=0, bcd_out=0, bit counter=0, internal shift register=0.
  - blank resets to all-ones except bit 0, which is 0.
- States: IDLE, SHIFT.
- IDLE:
  - If start=1 at a rising edge, load the shift register as {4*DIGITS zeros, bin_in}.
  - Clear the sticky overflow accumulator, set counter=0, busy=1, go to SHIFT.
  - start=0 leaves the state unchanged.
- SHIFT, each edge:
  - For every BCD digit >= 5, add 3 to that digit (4-bit, no carry into neighbour).
  - Then shift the whole register left by 1.
  - If the bit shifted out of the top digit is 1, set the sticky overflow accumulator.
  - Increment the counter.
- Termination:
  - On the edge that performs shift number BIN_W (counter == BIN_W-1), register the BCD field into bcd_out.
  - On that same edge, register the accumulator into overflow, set done=1 and busy=0, and return to IDLE.
- done is high for exactly one cycle. With start held low it returns to 0 on the next edge.
- Latency: start accepted at edge N gives done=1 and the new bcd_out in the cycle following edge N+BIN_W.
- Throughput: one conversion per BIN_W+1 cycles.
- start while busy=1 is ignored; there is no queueing. bin_in is don't-care except on an accepted start.
- Back-to-back: in the done cycle busy=0, so start=1 there is accepted at the next edge, and done drops to 0 at that edge.
- bcd_out and overflow hold their previous values during a conversion and change only on the done edge.
- Overflow case: bcd_out = bin_in mod 10^DIGITS and overflow=1.
- Reset asserted mid-conversion aborts immediately to reset values; no done is produced.
- Counter width: $clog2(BIN_W+1).
- Shift register width: 4*DIGITS+BIN_W.

Optional Feature:
- Macro: BCD_LZB_EN (leading-zero blanking).
- When defined:
  - The blank output exists and is registered on the done edge alongside bcd_out.
  - blank[k]=1 for k>=1 when digit k and all higher digits are zero.
  - blank[0] is always 0, so "0" still displays.
  - Example, DIGITS=4, result 0042: blank=4'b1100.
- When undefined: the blank port and its logic are absent, and all other behaviour is identical.

Test Plan:
1. Defaults, pulse start with bin_in=9999 -> done exactly 15 cycles after the start edge; bcd_out=16'h9999; overflow=0; busy high for 14 cycles.
2. Defaults, bin_in=0, then bin_in=1234 back-to-back (start high in the done cycle) -> first done gives 16'h0000; second done gives 16'h1234 exactly 15 cycles later; no idle gap.
3. Defaults, bin_in=16383 -> bcd_out=16'h6383, overflow=1. Then bin_in=500 -> bcd_out=16'h0500, overflow=0 (sticky cleared per conversion).
4. Start bin_in=4321, then 5 cycles later start=1 with bin_in=7777 -> ignored. done once with 16'h4321; bcd_out holds the previous value until that done.
5. Start bin_in=8888, assert rst asynchronously mid-cycle at iteration 7 -> busy/done/bcd_out/overflow go to 0 without waiting for a clock edge; no done pulse. After release, a new start with 2024 -> 16'h2024.
6. BIN_W=20, DIGITS=6, bin_in=999999 -> 24'h999999 after 21 cycles. With BCD_LZB_EN, bin_in=42 -> blank=6'b111100, and bin_in=0 -> blank=6'b111110.
